// File: rtl/invaders_dl_ctrl.sv
// invaders_dl_ctrl: ioctl download router, ROM write FIFO/drain and CPU reset sequencer
module invaders_dl_ctrl #(
  parameter int unsigned ROM_SIZE    = 'h2000,
  parameter int          DEPTH       = 4,
  parameter int          HOLD_CYCLES = 16
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  input  logic [7:0]  ioctl_index,
  output logic        ioctl_wait,
  output logic        dn_req,
  output logic [15:0] dn_addr,
  output logic [7:0]  dn_data,
  input  logic        dn_ack,
  output logic [7:0]  mod,
  output logic [7:0]  sw0,
  output logic [7:0]  sw1,
  output logic [7:0]  sw2,
  output logic        cpu_rst,
  output logic        rom_loaded,
  output logic        overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  typedef enum logic [1:0] {RUN, LOAD, FLUSH, HOLD} state_t;
  state_t state, state_next;
  logic [HW-1:0] cnt, cnt_next;
  logic [23:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [CW-1:0] count, count_next;
  logic rom_wr, push, pop, more, sw_wr;
  assign rom_wr = ioctl_wr && ioctl_index == 8'd0 && ioctl_addr < 25'(ROM_SIZE);
  assign push = rom_wr && count != CW'(DEPTH);
  assign pop = dn_req && dn_ack;
  assign more = count > CW'(1);
  assign count_next = count + CW'(push) - CW'(pop);
  assign sw_wr = ioctl_wr && ioctl_index == 8'd254 && ioctl_addr[24:3] == 22'd0;
  // next state and hold counter; a new download always wins over flush/hold
  always_comb begin
    state_next = state;
    cnt_next = cnt;
    unique case (state)
      RUN:   state_next = ioctl_download ? LOAD : RUN;
      LOAD:  state_next = ioctl_download ? LOAD : FLUSH;
      FLUSH: begin
        if (ioctl_download) state_next = LOAD;
        else if (count == '0 && !dn_req) begin
          state_next = HOLD;
          cnt_next = HW'(HOLD_CYCLES - 1);
        end
      end
      HOLD: begin
        if (ioctl_download) state_next = LOAD;
        else if (cnt == '0) state_next = RUN;
        else cnt_next = cnt - 1'b1;
      end
      default: state_next = HOLD;
    endcase
  end
  // state register; cpu_rst registered from the next state so it tracks it glitch-free
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state <= HOLD;
      cnt <= HW'(HOLD_CYCLES - 1);
      cpu_rst <= 1'b1;
    end else begin
      state <= state_next;
      cnt <= cnt_next;
      cpu_rst <= state_next != RUN;
    end
  end
  // FIFO storage, no reset needed since occupancy is tracked by count
  always_ff @(posedge clk_sys) begin
    if (push) mem[wp] <= {ioctl_addr[15:0], ioctl_dout};
  end
  // FIFO pointers, occupancy, early stall and sticky status flags
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
      ioctl_wait <= 1'b0;
      overflow <= 1'b0;
      rom_loaded <= 1'b0;
    end else begin
      if (push) wp <= wp + AW'(1);
      if (pop) rp <= rp + AW'(1);
      count <= count_next;
      ioctl_wait <= count_next >= CW'(DEPTH - 1);
      if (rom_wr && !push) overflow <= 1'b1;
      if (pop) rom_loaded <= 1'b1;
    end
  end
  // drain: the presented entry stays at the FIFO head until acked
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      dn_req <= 1'b0;
      dn_addr <= '0;
      dn_data <= '0;
    end else if (!dn_req && count != '0) begin
      dn_req <= 1'b1;
      {dn_addr, dn_data} <= mem[rp];
    end else if (pop) begin
      dn_req <= more;
      if (more) {dn_addr, dn_data} <= mem[rp + AW'(1)];
    end
  end
  // machine-select and DIP byte capture, decoded in any state
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      mod <= '0;
      sw0 <= '0;
      sw1 <= '0;
      sw2 <= '0;
    end else begin
      if (ioctl_wr && ioctl_index == 8'd1 && ioctl_addr == 25'd0) mod <= ioctl_dout;
      if (sw_wr && ioctl_addr[2:0] == 3'd0) sw0 <= ioctl_dout;
      if (sw_wr && ioctl_addr[2:0] == 3'd1) sw1 <= ioctl_dout;
      if (sw_wr && ioctl_addr[2:0] == 3'd2) sw2 <= ioctl_dout;
    end
  end
endmodule

// File: tb/tb_invaders_dl_ctrl.sv
// tb_invaders_dl_ctrl: scoreboard bench for the download sequencer
module tb_invaders_dl_ctrl;
  logic clk_sys = 1'b0, reset = 1'b1, ioctl_download = 1'b0, ioctl_wr = 1'b0, dn_ack = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0] ioctl_dout = '0, ioctl_index = '0;
  logic ioctl_wait, dn_req, cpu_rst, rom_loaded, overflow;
  logic [15:0] dn_addr;
  logic [7:0] dn_data, mod, sw0, sw1, sw2;
  int cyc = 0, vectors = 0, miscompares = 0, last_ack = 0, ack_mode = 0;
  bit wait_seen = 0;
  logic [23:0] exp_q[$];

  invaders_dl_ctrl dut (
    .clk_sys(clk_sys), .reset(reset), .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_index(ioctl_index),
    .ioctl_wait(ioctl_wait), .dn_req(dn_req), .dn_addr(dn_addr), .dn_data(dn_data),
    .dn_ack(dn_ack), .mod(mod), .sw0(sw0), .sw1(sw1), .sw2(sw2), .cpu_rst(cpu_rst),
    .rom_loaded(rom_loaded), .overflow(overflow)
  );

  always #5 clk_sys = ~clk_sys;
  always @(posedge clk_sys) cyc <= cyc + 1;

  // ack pattern: 0 = never, 1 = always, 2 = one cycle in four
  initial forever begin
    @(posedge clk_sys);
    #1;
    dn_ack = ack_mode == 1 || (ack_mode == 2 && cyc % 4 == 0);
  end

  // monitor: every accepted transfer is popped from the scoreboard and compared
  initial forever begin
    @(negedge clk_sys);
    if (ioctl_wait) wait_seen = 1;
    if (dn_req && dn_ack) begin
      logic [23:0] e;
      vectors++;
      last_ack = cyc;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL dn_unexpected got %h_%h required no transfer", dn_addr, dn_data);
      end else begin
        e = exp_q.pop_front();
        if ({dn_addr, dn_data} !== e) begin
          miscompares++;
          $display("FAIL dn_transfer got %h_%h required %h_%h", dn_addr, dn_data, e[23:8], e[7:0]);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout required finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s got %h required %h", name, got, want);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_sys);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] idx, input logic [24:0] a, input logic [7:0] d,
                      input bit honour, input bit expect_push);
    int t = 0;
    tick(1);
    while (honour && ioctl_wait && t < 100) begin
      ioctl_wr = 0;
      tick(1);
      t++;
    end
    if (t == 100) begin
      miscompares++;
      $display("FAIL wait_timeout got ioctl_wait=1 required release");
    end
    ioctl_wr = 1;
    ioctl_index = idx;
    ioctl_addr = a;
    ioctl_dout = d;
    if (expect_push) exp_q.push_back({a[15:0], d});
  endtask

  task automatic end_wr();
    tick(1);
    ioctl_wr = 0;
  endtask

  task automatic stream();
    ioctl_download = 1;
    for (int a = 0; a < 'h2000; a++) send(8'd0, 25'(a), 8'(a), 1, 1);
    end_wr();
    ioctl_download = 0;
  endtask

  task automatic wait_drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 2000) begin
      tick(1);
      t++;
    end
    if (t == 2000) begin
      miscompares++;
      $display("FAIL drain_timeout got %0d pending required 0", exp_q.size());
    end
  endtask

  initial begin
    int n, fall;
    tick(3);
    check("rst_cpu_rst", 32'(cpu_rst), 1);
    check("rst_dn_req", 32'(dn_req), 0);
    check("rst_dn_addr", 32'(dn_addr), 0);
    check("rst_dn_data", 32'(dn_data), 0);
    check("rst_wait", 32'(ioctl_wait), 0);
    check("rst_mod_sw", {mod, sw0, sw1, sw2}, 0);
    check("rst_flags", {rom_loaded, overflow}, 0);
    @(negedge clk_sys);
    reset = 0;
    n = 0;
    do begin
      tick(1);
      n++;
    end while (cpu_rst && n < 100);
    check("hold_after_reset", 32'(n), 16);
    check("run_rom_loaded", 32'(rom_loaded), 0);

    // full ROM with ack tied high: no stall expected
    ack_mode = 1;
    wait_seen = 0;
    stream();
    wait_drain();
    n = 0;
    while (cpu_rst && n < 100) begin
      tick(1);
      n++;
    end
    fall = cyc;
    // ack edge, one FLUSH cycle to see empty, then HOLD_CYCLES in HOLD
    check("cpu_rst_fall", 32'(fall), 32'(last_ack + 1 + 1 + 16));
    check("s1_no_wait", 32'(wait_seen), 0);
    check("s1_overflow", 32'(overflow), 0);
    check("s1_rom_loaded", 32'(rom_loaded), 1);

    // full ROM with slow memory: bench honours ioctl_wait
    ack_mode = 2;
    wait_seen = 0;
    stream();
    wait_drain();
    tick(25);
    check("s2_wait_seen", 32'(wait_seen), 1);
    check("s2_overflow", 32'(overflow), 0);
    check("s2_cpu_rst", 32'(cpu_rst), 0);

    // ignore wait with memory stalled: 4 kept, 2 dropped
    ack_mode = 0;
    tick(2);
    ioctl_download = 1;
    for (int a = 0; a < 6; a++) send(8'd0, 25'(a), 8'(8'h40 + a), 0, a < 4);
    end_wr();
    ioctl_download = 0;
    tick(2);
    check("ovf_flag", 32'(overflow), 1);
    check("ovf_wait", 32'(ioctl_wait), 1);
    check("ovf_req_head", {15'd0, dn_req, dn_addr}, 32'h1_0000);
    ack_mode = 1;
    wait_drain();
    tick(5);
    check("ovf_req_idle", 32'(dn_req), 0);

    // mod and DIP routing; nothing reaches the memory port
    tick(25);
    send(8'd1, 25'd0, 8'h06, 0, 0);
    send(8'd1, 25'd1, 8'h55, 0, 0);
    for (int a = 0; a < 8; a++) send(8'd254, 25'(a), 8'((a + 1) * 'h11), 0, 0);
    send(8'd254, 25'd8, 8'h99, 0, 0);
    send(8'd0, 25'h2000, 8'hAA, 0, 0);
    send(8'd7, 25'd0, 8'h77, 0, 0);
    end_wr();
    tick(3);
    check("mod", 32'(mod), 32'h06);
    check("sw0", 32'(sw0), 32'h11);
    check("sw1", 32'(sw1), 32'h22);
    check("sw2", 32'(sw2), 32'h33);
    check("route_no_req", 32'(dn_req), 0);

    // asynchronous reset with bytes buffered and a request outstanding
    ack_mode = 0;
    tick(1);
    send(8'd0, 25'h10, 8'hA0, 0, 0);
    send(8'd0, 25'h11, 8'hA1, 0, 0);
    end_wr();
    tick(2);
    check("pre_rst_req", {15'd0, dn_req, dn_addr}, 32'h1_0010);
    #2 reset = 1;
    #1;
    check("async_dn_req", 32'(dn_req), 0);
    check("async_cpu_rst", 32'(cpu_rst), 1);
    check("async_dn_addr", 32'(dn_addr), 0);
    @(negedge clk_sys);
    reset = 0;
    ack_mode = 1;
    tick(30);
    check("post_rst_req", 32'(dn_req), 0);
    check("post_rst_cpu", 32'(cpu_rst), 0);
    check("post_rst_flags", {rom_loaded, overflow}, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
